// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared widths, forward codes and stage-entry helpers for hazard logic
package hazard_scoreboard_pkg;
  localparam int AW = 5;
  localparam int TW = 2;
  localparam logic [TW-1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E = 2'd1;
  localparam logic [1:0] FWD_M = 2'd2;
  localparam logic [1:0] FWD_W = 2'd3;
  typedef logic [AW-1:0] reg_t;
  typedef logic [TW-1:0] tn_t;
  typedef struct packed {
    reg_t dst;
    tn_t tnew;
  } entry_t;
  function automatic tn_t sat_dec(tn_t x);
    return (x == '0) ? '0 : x - 1'b1;
  endfunction
  function automatic logic match(reg_t a, reg_t dst);
    return (a != '0) && (a == dst);
  endfunction
endpackage

// File: rtl/hazard_scoreboard_fwd_pick.sv
// hz_fwd_pick: nearest-matching-stage forward select, gated on the producer having its result
module hz_fwd_pick
  import hazard_scoreboard_pkg::*;
#(
  parameter int N = 3,
  parameter logic [N-1:0][1:0] CODES = '0
) (
  input  logic [AW-1:0]        src,
  input  logic [N-1:0][AW-1:0] dst,
  input  logic [N-1:0][TW-1:0] tnew,
  output logic [1:0]           sel
);
  always_comb begin
    sel = FWD_RF;
    for (int i = N - 1; i >= 0; i--)
      if (match(src, dst[i])) sel = (tnew[i] == '0) ? CODES[i] : FWD_RF;
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks E/M/W destinations with ageing Tnew to drive stall and forwarding selects
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] D_rs,
  input  logic [AW-1:0] D_rt,
  input  logic [TW-1:0] D_Tuse_rs,
  input  logic [TW-1:0] D_Tuse_rt,
  input  logic [AW-1:0] D_RFDst,
  input  logic [TW-1:0] D_Tnew,
  output logic          stall,
  output logic [1:0]    FwdD_rs,
  output logic [1:0]    FwdD_rt,
  output logic [1:0]    FwdE_rs,
  output logic [1:0]    FwdE_rt,
  output logic          FwdM_rt
);
  entry_t e, m, w;
  reg_t e_rs, e_rt, m_rt;
  logic [1:0] fm_sel;
  // W never needs checking: a producer always has its result by then
  assign stall = (match(D_rs, e.dst) && e.tnew > D_Tuse_rs) ||
                 (match(D_rs, m.dst) && m.tnew > D_Tuse_rs) ||
                 (match(D_rt, e.dst) && e.tnew > D_Tuse_rt) ||
                 (match(D_rt, m.dst) && m.tnew > D_Tuse_rt);
  always_ff @(posedge clk) begin
    if (reset) begin
      e <= '0;
      m <= '0;
      w <= '0;
      e_rs <= '0;
      e_rt <= '0;
      m_rt <= '0;
    end else begin
      w <= '{dst: m.dst, tnew: sat_dec(m.tnew)};
      m <= '{dst: e.dst, tnew: sat_dec(e.tnew)};
      m_rt <= e_rt;
      e <= stall ? '0 : '{dst: D_RFDst, tnew: D_Tnew};
      e_rs <= stall ? '0 : D_rs;
      e_rt <= stall ? '0 : D_rt;
    end
  end
  hz_fwd_pick #(.N(3), .CODES({FWD_W, FWD_M, FWD_E})) u_fd_rs (
    .src(D_rs), .dst({w.dst, m.dst, e.dst}), .tnew({w.tnew, m.tnew, e.tnew}), .sel(FwdD_rs)
  );
  hz_fwd_pick #(.N(3), .CODES({FWD_W, FWD_M, FWD_E})) u_fd_rt (
    .src(D_rt), .dst({w.dst, m.dst, e.dst}), .tnew({w.tnew, m.tnew, e.tnew}), .sel(FwdD_rt)
  );
  hz_fwd_pick #(.N(2), .CODES({FWD_W, FWD_M})) u_fe_rs (
    .src(e_rs), .dst({w.dst, m.dst}), .tnew({w.tnew, m.tnew}), .sel(FwdE_rs)
  );
  hz_fwd_pick #(.N(2), .CODES({FWD_W, FWD_M})) u_fe_rt (
    .src(e_rt), .dst({w.dst, m.dst}), .tnew({w.tnew, m.tnew}), .sel(FwdE_rt)
  );
  hz_fwd_pick #(.N(1), .CODES(FWD_W)) u_fm_rt (
    .src(m_rt), .dst(w.dst), .tnew(w.tnew), .sel(fm_sel)
  );
  assign FwdM_rt = (fm_sel == FWD_W);
endmodule
